// File: rtl/dvp_stream_tx.sv
// DVP-style camera bus transmitter: serialises RGB565 pixels into
// VSYNC/HREF framed bytes, high byte first, one byte per clock.
module dvp_stream_tx #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 144,
    parameter int VSYNC_W  = 3,
    parameter int V_BACK   = 17,
    parameter int V_FRONT  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        pix_req,
    input  logic [15:0] pix_data,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic        busy
);

    localparam int H_TOTAL = 2 * H_ACTIVE + H_BLANK;
    localparam int V_SUM   = VSYNC_W + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_SUM + 1);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_PRE   = HW'(H_TOTAL - 2);
    localparam logic [HW-1:0] H_BYTES = HW'(2 * H_ACTIVE);
    localparam logic [HW-1:0] H_REQ   = HW'(2 * H_ACTIVE - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_VFRONT
    } state_t;

    state_t          st_q, st_d;
    logic [HW-1:0]   h_q, h_d;
    logic [VW-1:0]   v_q, v_d;
    logic [VW-1:0]   v_last;
    logic [7:0]      lo_q;

    logic            req_d, vsync_d, href_d, hi_d;
    logic            fs_d, fd_d, busy_d;
    logic [7:0]      data_d;

    // Position counters advance every clock once a frame is running.
    always_comb begin
        st_d   = st_q;
        h_d    = h_q;
        v_d    = v_q;
        v_last = '0;
        unique case (st_q)
            S_VSYNC:  v_last = VW'(VSYNC_W - 1);
            S_VBACK:  v_last = VW'(V_BACK - 1);
            S_ACTIVE: v_last = VW'(V_ACTIVE - 1);
            S_VFRONT: v_last = VW'(V_FRONT - 1);
            default:  v_last = '0;
        endcase
        if (st_q == S_IDLE) begin
            if (en) begin
                st_d = S_VSYNC;
                h_d  = '0;
                v_d  = '0;
            end
        end else if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == v_last) begin
                v_d = '0;
                unique case (st_q)
                    S_VSYNC:  st_d = S_VBACK;
                    S_VBACK:  st_d = S_ACTIVE;
                    S_ACTIVE: st_d = S_VFRONT;
                    S_VFRONT: st_d = en ? S_VSYNC : S_IDLE;
                    default:  st_d = S_IDLE;
                endcase
            end else begin
                v_d = v_q + 1'b1;
            end
        end else begin
            h_d = h_q + 1'b1;
        end
    end

    // Outputs are decoded from the upcoming position and registered,
    // so each output lines up with the position counters.
    always_comb begin
        vsync_d = (st_d == S_VSYNC);
        href_d  = (st_d == S_ACTIVE) && (h_d < H_BYTES);
        hi_d    = href_d && !h_d[0];
        req_d   = ((st_d == S_ACTIVE) && !h_d[0] && (h_d < H_REQ))
                || ((h_d == H_PRE)
                    && (((st_d == S_VBACK) && (v_d == VW'(V_BACK - 1)))
                     || ((st_d == S_ACTIVE) && (v_d != VW'(V_ACTIVE - 1)))));
        fs_d    = (st_d == S_VSYNC) && (h_d == '0) && (v_d == '0);
        fd_d    = (st_d == S_VFRONT) && (h_d == H_LAST)
                && (v_d == VW'(V_FRONT - 1));
        busy_d  = (st_d != S_IDLE);
        data_d  = 8'h00;
        if (href_d)
            data_d = hi_d ? pix_data[15:8] : lo_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= S_IDLE;
            h_q         <= '0;
            v_q         <= '0;
            lo_q        <= 8'h00;
            pix_req     <= 1'b0;
            dvp_vsync   <= 1'b0;
            dvp_href    <= 1'b0;
            dvp_data    <= 8'h00;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            st_q        <= st_d;
            h_q         <= h_d;
            v_q         <= v_d;
            if (hi_d)
                lo_q    <= pix_data[7:0];
            pix_req     <= req_d;
            dvp_vsync   <= vsync_d;
            dvp_href    <= href_d;
            dvp_data    <= data_d;
            frame_start <= fs_d;
            frame_done  <= fd_d;
            busy        <= busy_d;
        end
    end

endmodule
